// File: rtl/timer_pkg.sv
// timer_pkg: state encoding and mode constants shared by the timer_ctrl slice
package timer_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t HOLD = 2'd2;
  localparam state_t DONE = 2'd3;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: command/config/status bundle; master drives start/stop/hold/mode/limit/prescale, slave returns count/busy/done
interface timer_ctrl_if #(parameter int N = 8, parameter int P = 8);
  logic         start, stop, hold, mode;
  logic [N-1:0] limit, count;
  logic [P-1:0] prescale;
  logic         busy, done;
  modport master(output start, stop, hold, mode, limit, prescale, input count, busy, done);
  modport slave(input start, stop, hold, mode, limit, prescale, output count, busy, done);
endinterface

// File: rtl/timer_core_cnt.sv
// timer_core_cnt: N-bit up-counter; ports clk, rst (async active-low), clr_i (sync clear, wins), en_i (increment), count_o
module timer_core_cnt #(parameter int N = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] count_o
);
  logic [N-1:0] count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else if (clr_i) count_q <= '0;
    else if (en_i) count_q <= count_q + 1'b1;
  assign count_o = count_q;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer; ports clk, rst (async active-low), bus (slave: commands/config in, count/busy/done out)
module timer_ctrl
  import timer_pkg::*;
#(parameter int N = 8, parameter int P = 8) (
  input logic        clk,
  input logic        rst,
  timer_ctrl_if.slave bus
);
  state_t       state_q, state_d;
  logic [P-1:0] presc_cnt_q, presc_cnt_d, presc_q;
  logic [N-1:0] limit_q, count;
  logic         mode_q, done_q, done_d;
  logic         live, active, tick, term, clr, en;
  assign live   = (state_q == RUN) || (state_q == HOLD);
  // HOLD with hold released counts on the same edge it returns to RUN, so a hold costs exactly its length
  assign active = live && !bus.hold;
  assign tick   = active && (presc_cnt_q == presc_q);
  assign term   = count == limit_q;
  always_comb begin
    state_d     = state_q;
    presc_cnt_d = presc_cnt_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    en          = 1'b0;
    if (bus.stop || bus.start) begin
      state_d     = bus.stop ? IDLE : RUN;
      presc_cnt_d = '0;
      clr         = 1'b1;
    end else if (live) begin
      state_d     = bus.hold ? HOLD : RUN;
      presc_cnt_d = active ? (tick ? '0 : presc_cnt_q + 1'b1) : presc_cnt_q;
      done_d      = tick && term;
      en          = tick && !term;
      clr         = tick && term && (mode_q == MODE_PERIODIC);
      state_d     = (tick && term && (mode_q == MODE_ONESHOT)) ? DONE : state_d;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      presc_cnt_q <= '0;
      done_q      <= 1'b0;
      limit_q     <= '0;
      presc_q     <= '0;
      mode_q      <= MODE_ONESHOT;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      done_q      <= done_d;
      if (bus.start && !bus.stop) begin
        limit_q <= bus.limit;
        presc_q <= bus.prescale;
        mode_q  <= bus.mode;
      end
    end
  timer_core_cnt #(.N(N)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .en_i   (en),
    .count_o(count)
  );
  assign bus.count = count;
  assign bus.busy  = live;
  assign bus.done  = done_q;
endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Sequencing controller around the team's free-running N-bit up-counter; turns it into a programmable interval timer.
- Adds start/stop/hold control, a prescaler, a terminal-count compare, one-shot and periodic (auto-restart) modes, and a one-cycle done strobe.
- Sits between a register/command interface and any logic that needs timed events: timeouts, periodic sampling, PWM frame timing.

Parameters:
- N, 8, counter width; also the width of limit and count.
- P, 8, prescaler width; sets the maximum divide of (2^P).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle command: latch config and (re)start from 0.
- stop  in  1  one-cycle command: abort and return to IDLE.
- hold  in  1  level: freeze the timer while 1 (only in RUN/HOLD).
- mode  in  1  0 = one-shot, 1 = periodic; sampled on start.
- limit  in  N  terminal count; sampled on start.
- prescale  in  P  tick every prescale+1 cycles; sampled on start.
- count  out  N  current timer value.
- busy  out  1  high in RUN or HOLD.
- done  out  1  one-cycle strobe when the terminal count is reached.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, presc_cnt=0, done=0, busy=0; latched config cleared to 0.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered; busy is decoded from the registered state.
- Command priority, evaluated each edge: stop > start > hold.
- stop in any state: next state IDLE, count=0, presc_cnt=0, done=0.
- start in any state (including RUN/HOLD, which is a restart):
  - latch limit_q, mode_q, presc_q;
  - count=0, presc_cnt=0;
  - next state RUN.
- RUN, tick generation:
  - tick = (presc_cnt == presc_q);
  - on tick presc_cnt=0, else presc_cnt+1;
  - presc_q=0 gives a tick every cycle.
- RUN, on tick with count != limit_q: count=count+1.
- RUN, on tick with count == limit_q: done=1 for exactly one cycle, then:
  - one-shot: next state DONE, count holds limit_q;
  - periodic: count=0, stay in RUN.
- Timing: count=1 is visible one edge after the first RUN edge. done rises (limit_q+1)*(presc_q+1) cycles after the start edge.
- Periodic: the done period is (limit_q+1)*(presc_q+1) cycles, with no gap.
- limit_q=0: done fires on every tick; count stays 0.
- hold=1 in RUN: next state HOLD; count and presc_cnt freeze; no tick is taken on that edge.
- HOLD with hold=0: return to RUN and resume the prescaler where it stopped.
- hold is ignored in IDLE and DONE.
- DONE: count holds, busy=0; leaves only on start or stop.
- done is 0 in every cycle not described above.
- Simultaneous start+stop: stop wins.
- Simultaneous start+hold: start wins; RUN begins even if hold stays high. hold applies from the next edge.
- Config inputs change only via start; changes while running have no effect.
- Arithmetic is unsigned and modulo 2^N/2^P. count never exceeds limit_q, so it never wraps past 2^N-1.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3);
  - mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- One natural sub-module: timer_core_cnt. It is the N-bit counter with synchronous clear, enable and async active-low reset. The FSM drives clear (start/stop/periodic wrap) and enable (tick && !terminal).
- The prescaler and compare stay in timer_ctrl.

Test Plan:
- Reset mid-run: assert rst=0 while count=5 -> count=0, busy=0, done=0 immediately, without waiting for a clock edge.
- One-shot, limit=3, prescale=0:
  - start -> count 0,1,2,3 on successive edges;
  - done=1 for exactly one cycle, 4 cycles after start;
  - state DONE, count holds 3, busy=0.
- Periodic, limit=2, prescale=1:
  - done strobes every 6 cycles;
  - count sequence 0,0,1,1,2,2,0,... with each value held 2 cycles;
  - busy stays 1.
- Hold, one-shot, limit=4, prescale=0:
  - raise hold at count=2 for 5 cycles -> count stays 2, no done;
  - after release, done arrives exactly 5 cycles later than the unheld run.
- Restart and priority:
  - start at count=3 -> count=0 next edge, new limit used;
  - start+stop together -> IDLE, count=0.
- Edge limits:
  - limit=0 periodic -> done every cycle, count=0;
  - limit=8'hFF, prescale=8'hFF one-shot -> done after exactly 65536 cycles.
